// File: rtl/eyeriss_pkg.sv
// Shared types and geometry helpers for the Eyeriss-style psum path.
// Derivations are functions so each block can evaluate them from its own generics.
package eyeriss_pkg;

   typedef enum logic [1:0] {
      StIdle,
      StCollect,
      StDone
   } collect_state_e;

   function automatic int unsigned data_width(input int unsigned top_bits,
                                              input int unsigned bot_bits);
      return top_bits + bot_bits;
   endfunction

   // Row distance between consecutive ofmap rows produced by the same PE column.
   function automatic int unsigned stride(input int unsigned array_h,
                                          input int unsigned array_w,
                                          input int unsigned kernel);
      return array_h + array_w - kernel;
   endfunction

   function automatic int unsigned out_dim(input int unsigned image_dim,
                                           input int unsigned kernel);
      return image_dim - kernel + 1;
   endfunction

   function automatic int unsigned total_pixels(input int unsigned out_h,
                                                input int unsigned out_w);
      return out_h * out_w;
   endfunction

   function automatic int unsigned cnt_width(input int unsigned n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/psum_rr_arbiter.sv
// Round-robin column pointer and one-hot pop select for the psum FIFOs.
// The pointer advances every enabled cycle whether or not the column popped.
module psum_rr_arbiter #(
   parameter int unsigned G_NUM_COLS = 6,
   parameter int unsigned PTR_W      = 3
) (
   input  logic                  clk_i,
   input  logic                  rst_ni,
   input  logic                  clear_i,
   input  logic                  en_i,
   input  logic [0:G_NUM_COLS-1] empty_i,
   output logic [PTR_W-1:0]      ptr_o,
   output logic [0:G_NUM_COLS-1] pop_o
);

   logic [PTR_W-1:0] ptr_q, ptr_d;

   always_comb begin
      ptr_d = ptr_q;
      if (clear_i) begin
         ptr_d = '0;
      end else if (en_i) begin
         ptr_d = (ptr_q == PTR_W'(G_NUM_COLS - 1)) ? '0 : ptr_q + PTR_W'(1);
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         ptr_q <= '0;
      end else begin
         ptr_q <= ptr_d;
      end
   end

   always_comb begin
      pop_o = '0;
      for (int c = 0; c < int'(G_NUM_COLS); c++) begin
         if (en_i && (ptr_q == PTR_W'(c)) && !empty_i[c]) begin
            pop_o[c] = 1'b1;
         end
      end
   end

   assign ptr_o = ptr_q;

endmodule

// File: rtl/psum_collector.sv
// Drains per-column psum FIFOs round-robin and writes one ofmap into BRAM,
// mapping each column's stream onto its strided set of output rows.
module psum_collector
   import eyeriss_pkg::*;
#(
   parameter int unsigned G_ARRAY_HEIGHT     = 5,
   parameter int unsigned G_ARRAY_WIDTH      = 6,
   parameter int unsigned G_KERNEL_SIZE      = 5,
   parameter int unsigned G_IMAGE_HEIGHT     = 28,
   parameter int unsigned G_IMAGE_WIDTH      = 28,
   parameter int unsigned G_TOP_BITS         = 2,
   parameter int unsigned G_BOT_BITS         = 14,
   parameter int unsigned G_OFMAP_ADDR_WIDTH = 10
) (
   input  logic                                                       clk_i,
   input  logic                                                       rst_ni,
   input  logic                                                       start_i,
   input  logic                                                       relu_en_i,
   input  logic [0:G_ARRAY_WIDTH-1]                                   psum_empty_i,
   input  logic [0:G_ARRAY_WIDTH-1][data_width(G_TOP_BITS, G_BOT_BITS)-1:0] psum_i,
   output logic [0:G_ARRAY_WIDTH-1]                                   psum_rd_en_o,
   output logic                                                       ofmap_wr_en_o,
   output logic [G_OFMAP_ADDR_WIDTH-1:0]                              ofmap_wr_addr_o,
   output logic [data_width(G_TOP_BITS, G_BOT_BITS)-1:0]              ofmap_wr_data_o,
   output logic                                                       busy_o,
   output logic                                                       done_o,
   output logic                                                       extra_o
);

   localparam int unsigned DATA_WIDTH = data_width(G_TOP_BITS, G_BOT_BITS);
   localparam int unsigned STRIDE     = stride(G_ARRAY_HEIGHT, G_ARRAY_WIDTH, G_KERNEL_SIZE);
   localparam int unsigned OUT_H      = out_dim(G_IMAGE_HEIGHT, G_KERNEL_SIZE);
   localparam int unsigned OUT_W      = out_dim(G_IMAGE_WIDTH, G_KERNEL_SIZE);
   localparam int unsigned TOTAL      = total_pixels(OUT_H, OUT_W);
   localparam int unsigned PTR_W      = cnt_width(G_ARRAY_WIDTH);
   localparam int unsigned COL_W      = cnt_width(OUT_W);
   localparam int unsigned ROW_W      = cnt_width(OUT_H + 1);
   localparam int unsigned PIX_W      = cnt_width(TOTAL + 1);

   collect_state_e state_q, state_d;

   logic                          relu_q, relu_d;
   logic                          extra_q, extra_d;
   logic [PIX_W-1:0]              pix_cnt_q, pix_cnt_d;
   logic [COL_W-1:0]              col_cnt_q [G_ARRAY_WIDTH];
   logic [COL_W-1:0]              col_cnt_d [G_ARRAY_WIDTH];
   logic [ROW_W-1:0]              row_cnt_q [G_ARRAY_WIDTH];
   logic [ROW_W-1:0]              row_cnt_d [G_ARRAY_WIDTH];
   logic                          wr_en_q, wr_en_d;
   logic [G_OFMAP_ADDR_WIDTH-1:0] wr_addr_q, wr_addr_d;
   logic [DATA_WIDTH-1:0]         wr_data_q, wr_data_d;

   logic [PTR_W-1:0]         ptr;
   logic [0:G_ARRAY_WIDTH-1] pop;
   logic                     arm;
   logic                     collecting;
   logic                     popped;
   logic [COL_W-1:0]         sel_col;
   logic [ROW_W-1:0]         sel_row_cnt;
   logic [DATA_WIDTH-1:0]    sel_data;
   logic [31:0]              row;
   logic                     in_range;

   assign arm        = (state_q == StIdle) && start_i;
   assign collecting = (state_q == StCollect);

   psum_rr_arbiter #(
      .G_NUM_COLS (G_ARRAY_WIDTH),
      .PTR_W      (PTR_W)
   ) u_arbiter (
      .clk_i   (clk_i),
      .rst_ni  (rst_ni),
      .clear_i (arm),
      .en_i    (collecting),
      .empty_i (psum_empty_i),
      .ptr_o   (ptr),
      .pop_o   (pop)
   );

   // Context of the column under the pointer; only meaningful when it pops.
   always_comb begin
      sel_col     = '0;
      sel_row_cnt = '0;
      sel_data    = '0;
      for (int c = 0; c < int'(G_ARRAY_WIDTH); c++) begin
         if (ptr == PTR_W'(c)) begin
            sel_col     = col_cnt_q[c];
            sel_row_cnt = row_cnt_q[c];
            sel_data    = psum_i[c];
         end
      end
      popped   = |pop;
      row      = 32'(ptr) + 32'(sel_row_cnt) * STRIDE;
      in_range = (row < OUT_H);
   end

   always_comb begin
      state_d   = state_q;
      relu_d    = relu_q;
      extra_d   = extra_q;
      pix_cnt_d = pix_cnt_q;
      col_cnt_d = col_cnt_q;
      row_cnt_d = row_cnt_q;
      wr_en_d   = 1'b0;
      wr_addr_d = wr_addr_q;
      wr_data_d = wr_data_q;

      unique case (state_q)
         StIdle: begin
            if (start_i) begin
               state_d   = StCollect;
               relu_d    = relu_en_i;
               extra_d   = 1'b0;
               pix_cnt_d = '0;
               for (int c = 0; c < int'(G_ARRAY_WIDTH); c++) begin
                  col_cnt_d[c] = '0;
                  row_cnt_d[c] = '0;
               end
            end
         end
         StCollect: begin
            // Pixels are counted as their writes leave the output register.
            if (wr_en_q) begin
               pix_cnt_d = pix_cnt_q + PIX_W'(1);
               if (pix_cnt_q == PIX_W'(TOTAL - 1)) begin
                  state_d = StDone;
               end
            end
            for (int c = 0; c < int'(G_ARRAY_WIDTH); c++) begin
               if (pop[c]) begin
                  if (col_cnt_q[c] == COL_W'(OUT_W - 1)) begin
                     col_cnt_d[c] = '0;
                     // Freeze the row once past the ofmap so it cannot wrap back in range.
                     if (in_range) begin
                        row_cnt_d[c] = row_cnt_q[c] + ROW_W'(1);
                     end
                  end else begin
                     col_cnt_d[c] = col_cnt_q[c] + COL_W'(1);
                  end
               end
            end
            if (popped) begin
               if (in_range) begin
                  wr_en_d   = 1'b1;
                  wr_addr_d = G_OFMAP_ADDR_WIDTH'(row * OUT_W + 32'(sel_col));
                  wr_data_d = (relu_q && sel_data[DATA_WIDTH-1]) ? '0 : sel_data;
               end else begin
                  extra_d = 1'b1;
               end
            end
         end
         StDone: begin
            state_d = StIdle;
         end
         default: begin
            state_d = StIdle;
         end
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q   <= StIdle;
         relu_q    <= 1'b0;
         extra_q   <= 1'b0;
         pix_cnt_q <= '0;
         col_cnt_q <= '{default: '0};
         row_cnt_q <= '{default: '0};
         wr_en_q   <= 1'b0;
         wr_addr_q <= '0;
         wr_data_q <= '0;
      end else begin
         state_q   <= state_d;
         relu_q    <= relu_d;
         extra_q   <= extra_d;
         pix_cnt_q <= pix_cnt_d;
         col_cnt_q <= col_cnt_d;
         row_cnt_q <= row_cnt_d;
         wr_en_q   <= wr_en_d;
         wr_addr_q <= wr_addr_d;
         wr_data_q <= wr_data_d;
      end
   end

   assign psum_rd_en_o    = pop;
   assign ofmap_wr_en_o   = wr_en_q;
   assign ofmap_wr_addr_o = wr_addr_q;
   assign ofmap_wr_data_o = wr_data_q;
   assign busy_o          = collecting;
   assign done_o          = (state_q == StDone);
   assign extra_o         = extra_q;

endmodule

// File: tb/tb_psum_collector.sv
// Bench for psum_collector: FIFO model feeding the DUT and a scoreboard of
// expected ofmap writes, filled as psums are loaded and drained as writes appear.
module tb_psum_collector;

   localparam int NCOL    = 6;
   localparam int DW      = 16;
   localparam int AW      = 10;
   localparam int TOTAL   = 576;
   localparam int PER_COL = 96;
   localparam int DEPTH   = 128;

   typedef struct packed {
      logic [AW-1:0] addr;
      logic [DW-1:0] data;
   } wr_t;

   logic                     clk_i     = 1'b0;
   logic                     rst_ni    = 1'b1;
   logic                     start_i   = 1'b0;
   logic                     relu_en_i = 1'b0;
   logic [0:NCOL-1]          psum_empty_i;
   logic [0:NCOL-1][DW-1:0]  psum_i;
   logic [0:NCOL-1]          psum_rd_en_o;
   logic                     ofmap_wr_en_o;
   logic [AW-1:0]            ofmap_wr_addr_o;
   logic [DW-1:0]            ofmap_wr_data_o;
   logic                     busy_o;
   logic                     done_o;
   logic                     extra_o;

   int checks   = 0;
   int failures = 0;

   logic [DW-1:0] fifo_mem [NCOL][DEPTH];
   logic [6:0]    rd_ptr [NCOL];
   logic [6:0]    wr_ptr [NCOL];
   wr_t           exp_q[$];
   logic [DW-1:0] ofmap [TOTAL];
   bit            written [TOTAL];
   int            wr_count   = 0;
   int            done_count = 0;
   logic [AW-1:0] first_addr;
   bit            tb_relu    = 1'b0;
   bit            lpv        = 1'b0;

   psum_collector dut (
      .clk_i           (clk_i),
      .rst_ni          (rst_ni),
      .start_i         (start_i),
      .relu_en_i       (relu_en_i),
      .psum_empty_i    (psum_empty_i),
      .psum_i          (psum_i),
      .psum_rd_en_o    (psum_rd_en_o),
      .ofmap_wr_en_o   (ofmap_wr_en_o),
      .ofmap_wr_addr_o (ofmap_wr_addr_o),
      .ofmap_wr_data_o (ofmap_wr_data_o),
      .busy_o          (busy_o),
      .done_o          (done_o),
      .extra_o         (extra_o)
   );

   always #5 clk_i = ~clk_i;

   // First-word-fall-through FIFO heads.
   always_comb begin
      psum_empty_i = '0;
      psum_i       = '0;
      for (int c = 0; c < NCOL; c++) begin
         psum_empty_i[c] = (rd_ptr[c] >= wr_ptr[c]);
         psum_i[c]       = fifo_mem[c][rd_ptr[c]];
      end
   end

   function automatic int elem_addr(input int c, input int k);
      return (c + (k / 24) * 6) * 24 + (k % 24);
   endfunction

   function automatic logic [DW-1:0] pattern(input int c, input int k);
      return DW'(elem_addr(c, k) * 256);
   endfunction

   task automatic push_psum(input int c, input logic [DW-1:0] d);
      int  k;
      wr_t e;
      k = int'(wr_ptr[c]);
      fifo_mem[c][wr_ptr[c]] = d;
      if (k < PER_COL) begin
         e.addr = AW'(elem_addr(c, k));
         e.data = (tb_relu && d[DW-1]) ? '0 : d;
         exp_q.push_back(e);
      end
      wr_ptr[c] = wr_ptr[c] + 7'd1;
   endtask

   task automatic fill_all(input int skip_col);
      @(posedge clk_i); #3;
      for (int c = 0; c < NCOL; c++) begin
         if (c != skip_col) begin
            for (int k = 0; k < PER_COL; k++) push_psum(c, pattern(c, k));
         end
      end
   endtask

   task automatic clear_tb();
      for (int c = 0; c < NCOL; c++) begin
         rd_ptr[c] = '0;
         wr_ptr[c] = '0;
      end
      exp_q.delete();
      for (int a = 0; a < TOTAL; a++) begin
         written[a] = 1'b0;
         ofmap[a]   = '0;
      end
      wr_count   = 0;
      done_count = 0;
   endtask

   task automatic pulse_start(input bit relu);
      @(posedge clk_i); #1;
      start_i   = 1'b1;
      relu_en_i = relu;
      @(posedge clk_i); #1;
      start_i   = 1'b0;
      relu_en_i = 1'b0;
   endtask

   task automatic wait_done(input int budget, output bit ok);
      ok = 1'b0;
      for (int i = 0; i < budget && !ok; i++) begin
         @(negedge clk_i);
         if (done_o === 1'b1) ok = 1'b1;
      end
      repeat (3) @(negedge clk_i);
   endtask

   // Monitor: write-latency check, pop legality and the scoreboard drain.
   initial begin : monitor
      logic [0:NCOL-1] pops;
      bit              exp_wr;
      bit              found;
      int              idx;
      int              col_of;
      int              a;
      forever begin
         @(negedge clk_i);
         pops   = psum_rd_en_o;
         exp_wr = rst_ni ? lpv : 1'b0;
         checks++;
         if (ofmap_wr_en_o !== exp_wr) begin
            failures++;
            $display("FAIL wr_latency: wr_en=%b required %b at %0t", ofmap_wr_en_o, exp_wr, $time);
         end
         if (|pops) begin
            checks++;
            if (busy_o !== 1'b1 || $countones(pops) != 1 || (pops & psum_empty_i) != '0) begin
               failures++;
               $display("FAIL pop_guard: pops=%b busy=%b empty=%b required one pop, busy, non-empty",
                        pops, busy_o, psum_empty_i);
            end
         end
         if (ofmap_wr_en_o === 1'b1) begin
            a      = int'(ofmap_wr_addr_o);
            col_of = (a / 24) % 6;
            found  = 1'b0;
            idx    = 0;
            foreach (exp_q[i]) begin
               if (!found && ((int'(exp_q[i].addr) / 24) % 6) == col_of) begin
                  idx   = i;
                  found = 1'b1;
               end
            end
            checks++;
            if (!found) begin
               failures++;
               $display("FAIL sb_unexpected: addr=%0d data=%h required no write", a, ofmap_wr_data_o);
            end else begin
               if (exp_q[idx].addr !== ofmap_wr_addr_o || exp_q[idx].data !== ofmap_wr_data_o) begin
                  failures++;
                  $display("FAIL sb_write: addr=%0d data=%h required addr=%0d data=%h", a,
                           ofmap_wr_data_o, exp_q[idx].addr, exp_q[idx].data);
               end
               exp_q.delete(idx);
            end
            if (a < TOTAL) begin
               checks++;
               if (written[a]) begin
                  failures++;
                  $display("FAIL dup_addr: addr=%0d written twice, required once", a);
               end
               written[a] = 1'b1;
               ofmap[a]   = ofmap_wr_data_o;
            end
            if (wr_count == 0) first_addr = ofmap_wr_addr_o;
            wr_count++;
         end
         if (done_o === 1'b1) done_count++;
         @(posedge clk_i); #1;
         lpv = 1'b0;
         if (rst_ni) begin
            for (int c = 0; c < NCOL; c++) begin
               if (pops[c]) begin
                  if (int'(rd_ptr[c]) < PER_COL) lpv = 1'b1;
                  rd_ptr[c] = rd_ptr[c] + 7'd1;
               end
            end
         end
      end
   end

   task automatic test_reset();
      clear_tb();
      fill_all(-1);
      #2 rst_ni = 1'b0;
      start_i = 1'b1;
      #12;
      checks++; if (psum_rd_en_o !== '0) begin failures++; $display("FAIL rst_rd_en: got %b required 0", psum_rd_en_o); end
      checks++; if (ofmap_wr_en_o !== 1'b0) begin failures++; $display("FAIL rst_wr_en: got %b required 0", ofmap_wr_en_o); end
      checks++; if (ofmap_wr_addr_o !== '0) begin failures++; $display("FAIL rst_addr: got %0d required 0", ofmap_wr_addr_o); end
      checks++; if (ofmap_wr_data_o !== '0) begin failures++; $display("FAIL rst_data: got %h required 0", ofmap_wr_data_o); end
      checks++; if (busy_o !== 1'b0) begin failures++; $display("FAIL rst_busy: got %b required 0", busy_o); end
      checks++; if (done_o !== 1'b0) begin failures++; $display("FAIL rst_done: got %b required 0", done_o); end
      checks++; if (extra_o !== 1'b0) begin failures++; $display("FAIL rst_extra: got %b required 0", extra_o); end
      start_i = 1'b0;
      @(negedge clk_i); #2 rst_ni = 1'b1;
      repeat (5) @(negedge clk_i);
      checks++;
      if (rd_ptr[0] !== '0 || wr_count != 0 || busy_o !== 1'b0) begin
        failures++;
        $display("FAIL idle_no_pop: rd_ptr0=%0d writes=%0d busy=%b required 0/0/0", rd_ptr[0], wr_count, busy_o);
      end
      clear_tb();
   endtask

   task automatic test_default();
      bit ok;
      clear_tb();
      tb_relu = 1'b0;
      fill_all(-1);
      pulse_start(1'b0);
      @(negedge clk_i);
      checks++; if (busy_o !== 1'b1) begin failures++; $display("FAIL def_busy: got %b required 1", busy_o); end
      wait_done(3000, ok);
      checks++; if (!ok) begin failures++; $display("FAIL def_timeout: done not seen, required done"); end
      checks++; if (wr_count != TOTAL) begin failures++; $display("FAIL def_count: got %0d required %0d", wr_count, TOTAL); end
      checks++; if (done_count != 1) begin failures++; $display("FAIL def_done_once: got %0d required 1", done_count); end
      checks++; if (extra_o !== 1'b0) begin failures++; $display("FAIL def_extra: got %b required 0", extra_o); end
      checks++; if (exp_q.size() != 0) begin failures++; $display("FAIL def_sb_left: got %0d required 0", exp_q.size()); end
      checks++; if (busy_o !== 1'b0) begin failures++; $display("FAIL def_idle: busy=%b required 0", busy_o); end
      checks++; if (ofmap[128] !== 16'h8000) begin failures++; $display("FAIL def_msb_pass: got %h required 8000", ofmap[128]); end
      checks++; if (ofmap[256] !== 16'h0000) begin failures++; $display("FAIL def_wrap256: got %h required 0000", ofmap[256]); end
      checks++; if (ofmap[300] !== 16'h2C00) begin failures++; $display("FAIL def_addr300: got %h required 2c00", ofmap[300]); end
      checks++; if (ofmap[575] !== 16'h3F00) begin failures++; $display("FAIL def_addr575: got %h required 3f00", ofmap[575]); end
   endtask

   task automatic test_stall_col3();
      bit ok;
      int bad;
      int cnt;
      clear_tb();
      fill_all(3);
      pulse_start(1'b0);
      repeat (200) @(negedge clk_i);
      bad = 0;
      for (int a = 0; a < TOTAL; a++) if (written[a] && ((a / 24) % 6) == 3) bad++;
      checks++; if (bad != 0) begin failures++; $display("FAIL stall_rows: got %0d writes to col3 rows required 0", bad); end
      checks++;
      if (wr_count < 100 || wr_count > 480) begin
         failures++;
         $display("FAIL stall_progress: got %0d writes required 100..480", wr_count);
      end
      @(posedge clk_i); #3;
      for (int k = 0; k < PER_COL; k++) push_psum(3, pattern(3, k));
      wait_done(3000, ok);
      checks++; if (!ok) begin failures++; $display("FAIL stall_timeout: done not seen, required done"); end
      cnt = 0;
      for (int a = 0; a < TOTAL; a++) if (written[a]) cnt++;
      checks++; if (cnt != TOTAL || wr_count != TOTAL) begin
         failures++; $display("FAIL stall_count: unique=%0d writes=%0d required %0d", cnt, wr_count, TOTAL);
      end
      checks++; if (exp_q.size() != 0) begin failures++; $display("FAIL stall_sb_left: got %0d required 0", exp_q.size()); end
   endtask

   task automatic test_relu();
      bit ok;
      clear_tb();
      tb_relu = 1'b1;
      @(posedge clk_i); #3;
      for (int c = 0; c < NCOL; c++) begin
         for (int k = 0; k < PER_COL; k++) push_psum(c, (c == 0 && k == 0) ? 16'h8001 : 16'h7FFF);
      end
      pulse_start(1'b1);
      wait_done(3000, ok);
      checks++; if (!ok) begin failures++; $display("FAIL relu_timeout: done not seen, required done"); end
      checks++; if (ofmap[0] !== 16'h0000) begin failures++; $display("FAIL relu_clamp: got %h required 0000", ofmap[0]); end
      checks++; if (ofmap[1] !== 16'h7FFF) begin failures++; $display("FAIL relu_pass: got %h required 7fff", ofmap[1]); end
      checks++; if (wr_count != TOTAL) begin failures++; $display("FAIL relu_count: got %0d required %0d", wr_count, TOTAL); end
      tb_relu = 1'b0;
   endtask

   task automatic test_extra();
      bit ok;
      int bad;
      clear_tb();
      fill_all(-1);
      push_psum(0, 16'hBEEF);
      pulse_start(1'b0);
      wait_done(3000, ok);
      checks++; if (!ok) begin failures++; $display("FAIL extra_timeout: done not seen, required done"); end
      checks++; if (extra_o !== 1'b1) begin failures++; $display("FAIL extra_set: got %b required 1", extra_o); end
      checks++; if (rd_ptr[0] !== 7'd97) begin failures++; $display("FAIL extra_popped: got %0d required 97", rd_ptr[0]); end
      bad = 0;
      for (int a = 0; a < TOTAL; a++) if (ofmap[a] !== DW'(a * 256)) bad++;
      checks++; if (bad != 0 || wr_count != TOTAL) begin
         failures++; $display("FAIL extra_ofmap: got %0d bad words, %0d writes required 0, %0d", bad, wr_count, TOTAL);
      end
      repeat (5) @(negedge clk_i);
      checks++; if (extra_o !== 1'b1) begin failures++; $display("FAIL extra_sticky: got %b required 1", extra_o); end
   endtask

   task automatic test_reset_mid();
      bit ok;
      clear_tb();
      fill_all(-1);
      pulse_start(1'b0);
      @(negedge clk_i);
      checks++; if (extra_o !== 1'b0) begin failures++; $display("FAIL rmid_extra_clr: got %b required 0", extra_o); end
      ok = 1'b0;
      for (int i = 0; i < 1000 && !ok; i++) begin
         @(negedge clk_i);
         if (wr_count >= 100) ok = 1'b1;
      end
      checks++; if (!ok) begin failures++; $display("FAIL rmid_reach100: got %0d writes required 100", wr_count); end
      #2 rst_ni = 1'b0;
      #1;
      checks++;
      if (ofmap_wr_en_o !== 1'b0 || psum_rd_en_o !== '0 || busy_o !== 1'b0 || done_o !== 1'b0 ||
          ofmap_wr_addr_o !== '0 || ofmap_wr_data_o !== '0) begin
         failures++;
         $display("FAIL rmid_outputs: wr=%b rd=%b busy=%b done=%b addr=%0d data=%h required all 0",
                  ofmap_wr_en_o, psum_rd_en_o, busy_o, done_o, ofmap_wr_addr_o, ofmap_wr_data_o);
      end
      clear_tb();
      @(negedge clk_i); #2 rst_ni = 1'b1;
      fill_all(-1);
      pulse_start(1'b0);
      wait_done(3000, ok);
      checks++; if (!ok) begin failures++; $display("FAIL rmid_timeout: done not seen, required done"); end
      checks++; if (first_addr !== '0) begin failures++; $display("FAIL rmid_first_addr: got %0d required 0", first_addr); end
      checks++; if (wr_count != TOTAL) begin failures++; $display("FAIL rmid_count: got %0d required %0d", wr_count, TOTAL); end
   endtask

   task automatic test_back_to_back();
      bit ok;
      clear_tb();
      fill_all(-1);
      pulse_start(1'b0);
      repeat (300) @(negedge clk_i);
      pulse_start(1'b1);
      wait_done(3000, ok);
      checks++; if (!ok) begin failures++; $display("FAIL b2b_timeout: done not seen, required done"); end
      checks++; if (wr_count != TOTAL) begin failures++; $display("FAIL b2b_count: got %0d required %0d", wr_count, TOTAL); end
      checks++; if (exp_q.size() != 0) begin failures++; $display("FAIL b2b_sb_left: got %0d required 0", exp_q.size()); end
      repeat (10) @(negedge clk_i);
      checks++; if (done_count != 1) begin failures++; $display("FAIL b2b_done_once: got %0d required 1", done_count); end
      checks++; if (busy_o !== 1'b0) begin failures++; $display("FAIL b2b_idle: busy=%b required 0", busy_o); end
   endtask

   initial begin : watchdog
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
      $fatal(1, "watchdog");
   end

   initial begin : main
      test_reset();
      test_default();
      test_stall_col3();
      test_relu();
      test_extra();
      test_reset_mid();
      test_back_to_back();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/psum_collector.md
PSUM_COLLECTOR -- requirements
Module: psum_collector

Interface
REQ-001 SHALL have parameters (name, default, meaning): G_ARRAY_HEIGHT 5 PE rows; G_ARRAY_WIDTH 6 PE columns / psum FIFOs; G_KERNEL_SIZE 5 filter size; G_IMAGE_HEIGHT 28; G_IMAGE_WIDTH 28; G_TOP_BITS 2 integer bits; G_BOT_BITS 14 fraction bits; G_OFMAP_ADDR_WIDTH 10 ofmap BRAM address bits.
REQ-002 SHALL have ports (name, direction, width, meaning): clk_i in 1 sole clock; rst_ni in 1 reset, asynchronous, active-low.
REQ-003 start_i in 1 one-cycle pulse that arms collection of one ofmap.
REQ-004 relu_en_i in 1 clamps negative psums to zero when high; sampled at start_i.
REQ-005 psum_empty_i in [0:G_ARRAY_WIDTH-1] per-column FIFO empty flags.
REQ-006 psum_i in [0:G_ARRAY_WIDTH-1][DATA_WIDTH-1:0] per-column FIFO heads; first-word-fall-through, valid while empty low.
REQ-007 psum_rd_en_o out [0:G_ARRAY_WIDTH-1] per-column pop strobes.
REQ-008 ofmap_wr_en_o out 1, ofmap_wr_addr_o out G_OFMAP_ADDR_WIDTH, ofmap_wr_data_o out DATA_WIDTH: ofmap BRAM write port.
REQ-009 busy_o out 1 high in COLLECT; done_o out 1 one-cycle completion pulse; extra_o out 1 sticky, excess psum seen.

Function
REQ-010 Derived: DATA_WIDTH=G_TOP_BITS+G_BOT_BITS; STRIDE=G_ARRAY_HEIGHT+G_ARRAY_WIDTH-G_KERNEL_SIZE (6); OUT_H=G_IMAGE_HEIGHT-G_KERNEL_SIZE+1 (24); OUT_W likewise (24); TOTAL=OUT_H*OUT_W (576).
REQ-011 FSM states IDLE, COLLECT, DONE; IDLE->COLLECT on start_i; COLLECT->DONE on the cycle the TOTAL-th write is issued; DONE->IDLE unconditionally after one cycle.
REQ-012 On start_i in IDLE: clear per-column col_cnt/row_cnt, pixel counter, round-robin pointer to 0, extra_o; latch relu_en_i.
REQ-013 start_i in COLLECT or DONE SHALL be ignored.
REQ-014 In COLLECT, each cycle the pointer selects column p; psum_rd_en_o[p] asserts combinationally iff psum_empty_i[p]=0; all other strobes 0; at most one pop per cycle.
REQ-015 Pointer advances p->(p+1) mod G_ARRAY_WIDTH every COLLECT cycle, popped or not.
REQ-016 Popped element maps to row = p + row_cnt[p]*STRIDE, col = col_cnt[p]; col_cnt wraps OUT_W-1->0 incrementing row_cnt.
REQ-017 If row < OUT_H: write issued next cycle, ofmap_wr_addr_o = row*OUT_W+col, ofmap_wr_data_o = psum (or 0 if relu latched and MSB set), pixel counter +1.
REQ-018 If row >= OUT_H: element popped and discarded, no write, extra_o set.
REQ-019 Pop-to-write latency exactly 1 cycle; write outputs registered; ofmap_wr_en_o high exactly one cycle per accepted psum.
REQ-020 done_o SHALL pulse in DONE; busy_o high only in COLLECT; no pops in IDLE or DONE.

Reset
REQ-021 On rst_ni low, asynchronously: state IDLE, all counters 0, psum_rd_en_o all 0, ofmap_wr_en_o 0, addr/data 0, busy_o 0, done_o 0, extra_o 0.
REQ-022 Reset mid-COLLECT SHALL abandon the ofmap; the pending write SHALL not be issued after reset release.

Structure
REQ-023 DATA_WIDTH, STRIDE, OUT_H/OUT_W/TOTAL derivation functions and the state enum SHALL live in shared package eyeriss_pkg.
REQ-024 One sub-module, psum_rr_arbiter (pointer plus one-hot pop select), is natural; counters and write pipeline stay in psum_collector.

Verification
REQ-025 Defaults, all six FIFOs model preloaded with 4 rows x 24 psums = 0x0100*(row*24+col) -> 576 writes, addr k carries data 0x0100*k mod 2^16, done_o once, extra_o 0.
REQ-026 Column 3 FIFO empty for 200 cycles then filled -> other columns proceed, no write ever for rows 3/9/15/21 until fill, final count 576, no duplicate addresses.
REQ-027 relu_en_i=1 with psum 0x8001 at row 0 col 0 -> addr 0 written 0x0000; 0x7FFF elsewhere passes unchanged.
REQ-028 Column 0 supplies a 97th psum -> discarded, extra_o=1 and stays 1, ofmap contents unchanged.
REQ-029 rst_ni low for 1 cycle after 100 writes, then start_i -> all outputs 0 during reset, collection restarts at addr 0, 576 writes total after restart.
REQ-030 start_i pulsed again mid-COLLECT -> ignored, counters unaffected, single done_o.
